// File: rtl/score_calculator_if.sv
// Bus between the game logic and the score calculator: event inputs in,
// registered score/lives/combo/status out.
interface score_calculator_if;
  logic       game_start;
  logic       hit_in;
  logic       miss_in;
  logic       frame_tick;
  logic [6:0] score;
  logic [1:0] lives;
  logic [2:0] combo;
  logic       playing;
  logic       game_over;

  modport master (
    output game_start, hit_in, miss_in, frame_tick,
    input  score, lives, combo, playing, game_over
  );

  modport slave (
    input  game_start, hit_in, miss_in, frame_tick,
    output score, lives, combo, playing, game_over
  );
endinterface

// File: rtl/score_calculator.sv
// Game score keeper: edge-detected hit/miss/start events drive an IDLE/PLAY/OVER
// FSM with a saturating combo score, double-buffered onto frame_tick.
module score_calculator #(
  parameter int MAX_SCORE  = 99,
  parameter int INIT_LIVES = 3,
  parameter int COMBO_LEN  = 5
) (
  input logic               clk,
  input logic               reset_n,
  score_calculator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [7:0] MaxScore8 = 8'(MAX_SCORE);

  state_t     state_q, state_d;
  logic       start_q, hit_q, miss_q;
  logic [6:0] score_acc_q, score_acc_d;
  logic [6:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic [2:0] combo_q, combo_d;
  logic       playing_q, playing_d;
  logic       game_over_q, game_over_d;
  logic       start_ev, hit_ev, miss_ev;
  logic       combo_done;
  logic [7:0] inc, sum;

  always_comb begin
    start_ev    = bus.game_start & ~start_q;
    hit_ev      = bus.hit_in & ~hit_q;
    miss_ev     = bus.miss_in & ~miss_q;
    state_d     = state_q;
    score_acc_d = score_acc_q;
    lives_d     = lives_q;
    combo_d     = combo_q;
    // The display buffer always samples the accumulator as it was before this edge.
    score_d     = bus.frame_tick ? score_acc_q : score_q;
    combo_done  = (combo_q + 3'd1) == 3'(COMBO_LEN);
    inc         = combo_done ? 8'd2 : 8'd1;
    sum         = {1'b0, score_acc_q} + inc;

    unique case (state_q)
      PLAY: begin
        if (miss_ev) begin
          combo_d = '0;
          if (lives_q <= 2'd1) begin
            lives_d = '0;
            state_d = OVER;
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end else if (hit_ev) begin
          combo_d     = combo_done ? 3'd0 : combo_q + 3'd1;
          score_acc_d = (sum > MaxScore8) ? MaxScore8[6:0] : sum[6:0];
        end
      end
      default: begin
        if (start_ev) begin
          state_d     = PLAY;
          score_acc_d = '0;
          combo_d     = '0;
          lives_d     = 2'(INIT_LIVES);
        end
      end
    endcase

    playing_d   = (state_d == PLAY);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_acc_q <= '0;
      score_q     <= '0;
      lives_q     <= '0;
      combo_q     <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.game_start;
      hit_q       <= bus.hit_in;
      miss_q      <= bus.miss_in;
      score_acc_q <= score_acc_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      combo_q     <= combo_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.combo     = combo_q;
  assign bus.playing   = playing_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_score_calculator.sv
// Directed bench for score_calculator: a behavioural game model predicts every
// cycle, and expected display scores queue up on each frame_tick until sampled.
module tb_score_calculator;
  localparam int MaxScore  = 99;
  localparam int InitLives = 3;
  localparam int ComboLen  = 5;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  score_calculator_if bus ();

  score_calculator #(
    .MAX_SCORE (MaxScore),
    .INIT_LIVES(InitLives),
    .COMBO_LEN (ComboLen)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model state: 0 idle, 1 play, 2 over
  int m_state, m_acc, m_lives, m_combo;
  logic m_start_q, m_hit_q, m_miss_q;
  int exp_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_state = 0; m_acc = 0; m_lives = 0; m_combo = 0;
    m_start_q = 1'b0; m_hit_q = 1'b0; m_miss_q = 1'b0;
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic m, input logic t);
    logic se, he, me;
    int exp_score;
    bus.game_start = s; bus.hit_in = h; bus.miss_in = m; bus.frame_tick = t;
    se = s && !m_start_q;
    he = h && !m_hit_q;
    me = m && !m_miss_q;
    if (t) exp_q.push_back(m_acc);
    if (m_state == 1) begin
      if (me) begin
        m_combo = 0;
        m_lives = m_lives - 1;
        if (m_lives == 0) m_state = 2;
      end else if (he) begin
        if (m_combo + 1 == ComboLen) begin
          m_combo = 0;
          m_acc = (m_acc + 2 > MaxScore) ? MaxScore : m_acc + 2;
        end else begin
          m_combo = m_combo + 1;
          m_acc = (m_acc + 1 > MaxScore) ? MaxScore : m_acc + 1;
        end
      end
    end else if (se) begin
      m_state = 1; m_acc = 0; m_combo = 0; m_lives = InitLives;
    end
    m_start_q = s; m_hit_q = h; m_miss_q = m;
    @(posedge clk); #1;
    if (t) begin
      exp_score = exp_q.pop_front();
      checkOutput("score", 32'(bus.score), 32'(exp_score));
    end
    checkOutput("lives", 32'(bus.lives), 32'(m_lives));
    checkOutput("combo", 32'(bus.combo), 32'(m_combo));
    checkOutput("playing", 32'(bus.playing), 32'(m_state == 1));
    checkOutput("game_over", 32'(bus.game_over), 32'(m_state == 2));
  endtask

  task automatic hitPulse();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic missPulse();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.game_start = 1'b0; bus.hit_in = 1'b0; bus.miss_in = 1'b0; bus.frame_tick = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_score", 32'(bus.score), 32'd0);
    checkOutput("rst_lives", 32'(bus.lives), 32'd0);
    checkOutput("rst_combo", 32'(bus.combo), 32'd0);
    checkOutput("rst_playing", 32'(bus.playing), 32'd0);
    checkOutput("rst_game_over", 32'(bus.game_over), 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Start, three hits, one frame
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) hitPulse();
    tick();
    checkOutput("three_hits_score", 32'(bus.score), 32'd3);
    checkOutput("three_hits_combo", 32'(bus.combo), 32'd3);
    checkOutput("three_hits_lives", 32'(bus.lives), 32'd3);

    // Shift combo phase, then a full combo of five from combo=0
    hitPulse();
    missPulse();
    tick();
    checkOutput("after_miss_score", 32'(bus.score), 32'd4);
    repeat (5) hitPulse();
    tick();
    checkOutput("combo_score", 32'(bus.score), 32'd10);
    checkOutput("combo_reset", 32'(bus.combo), 32'd0);

    // Climb to 98 with combo at 4, then saturate at the ceiling
    repeat (74) hitPulse();
    tick();
    checkOutput("pre_sat_score", 32'(bus.score), 32'd98);
    hitPulse();
    tick();
    checkOutput("sat_combo_score", 32'(bus.score), 32'd99);
    hitPulse();
    tick();
    checkOutput("sat_hold_score", 32'(bus.score), 32'd99);

    // Lose remaining lives; hits in OVER are ignored
    missPulse();
    missPulse();
    checkOutput("over_flag", 32'(bus.game_over), 32'd1);
    hitPulse();
    tick();
    checkOutput("over_score", 32'(bus.score), 32'd99);

    // Restart coincident with frame_tick: old total shows first
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("restart_old_score", 32'(bus.score), 32'd99);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("restart_new_score", 32'(bus.score), 32'd0);

    // Hit and miss together at combo=2, lives=2
    missPulse();
    hitPulse();
    hitPulse();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("hit_miss_lives", 32'(bus.lives), 32'd1);
    checkOutput("hit_miss_combo", 32'(bus.combo), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("hit_miss_score", 32'(bus.score), 32'd2);

    missPulse();
    checkOutput("game_over", 32'(bus.game_over), 32'd1);
    checkOutput("over_lives", 32'(bus.lives), 32'd0);
    hitPulse();
    tick();
    checkOutput("over_ignore_score", 32'(bus.score), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("replay_lives", 32'(bus.lives), 32'd3);
    tick();
    checkOutput("replay_score", 32'(bus.score), 32'd0);

    // Hit held for 100 cycles, first cycle coincident with frame_tick
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("held_first_tick", 32'(bus.score), 32'd0);
    for (int i = 1; i < 100; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, (i == 50 || i == 99));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("held_score", 32'(bus.score), 32'd1);
    checkOutput("held_combo", 32'(bus.combo), 32'd1);

    // Mid-game reset with game_start held across release
    reset_n = 1'b0;
    bus.game_start = 1'b1;
    modelReset();
    #1;
    checkOutput("async_rst_score", 32'(bus.score), 32'd0);
    checkOutput("async_rst_playing", 32'(bus.playing), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("held_start_playing", 32'(bus.playing), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("held_start_score", 32'(bus.score), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/score_calculator.md
SCORE_CALCULATOR -- requirements
Module: score_calculator

Interface
REQ-001 Parameter: MAX_SCORE, default 99, saturation ceiling of the score; it is the largest value the downstream two-digit renderer can show.
REQ-002 Parameter: INIT_LIVES, default 3, lives loaded on game start (legal range 1..3).
REQ-003 Parameter: COMBO_LEN, default 5, consecutive hits that earn one bonus point (legal range 2..7).
REQ-004 Port: clk  input  1  single system clock (pixel clock domain); all inputs synchronous to it.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: game_start  input  1  level; its rising edge requests a new game.
REQ-007 Port: hit_in  input  1  level from collision logic; its rising edge is one hit.
REQ-008 Port: miss_in  input  1  level from collision logic; its rising edge is one miss.
REQ-009 Port: frame_tick  input  1  one-cycle pulse at start of vertical blanking.
REQ-010 Port: score  output  7  displayed score (0..MAX_SCORE); changes only on frame_tick.
REQ-011 Port: lives  output  2  remaining lives.
REQ-012 Port: combo  output  3  current consecutive-hit count (0..COMBO_LEN-1).
REQ-013 Port: playing  output  1  high in state PLAY.
REQ-014 Port: game_over  output  1  high in state OVER.

Function
REQ-015 Edge detection: each of game_start, hit_in and miss_in shall be registered once; an event is the input at 1 while its registered copy is 0; the event shall act on the same clock edge at which it is detected.
REQ-016 FSM states: IDLE (after reset), PLAY, OVER; all outputs shall be registered.
REQ-017 IDLE -> PLAY on a start event; OVER -> PLAY on a start event; a start event in PLAY shall be ignored.
REQ-018 Entry to PLAY shall set score_acc=0, combo=0 and lives=INIT_LIVES on the same edge.
REQ-019 Hit in PLAY: combo+1; if combo+1 == COMBO_LEN then score_acc += 2 and combo=0, else score_acc += 1.
REQ-020 Score arithmetic shall saturate: score_acc = min(score_acc + inc, MAX_SCORE), computed at 8 bits with no wrap (e.g. 98+2 -> 99, 99+1 -> 99).
REQ-021 Miss in PLAY: combo=0 and lives-1; if lives was 1, lives=0 and the state becomes OVER on the same edge.
REQ-022 Simultaneous hit and miss events in one cycle: the miss shall take effect and the hit shall be discarded.
REQ-023 In IDLE and OVER, hit and miss events shall be ignored and score_acc, combo and lives shall hold.
REQ-024 Double buffer: on frame_tick, score <= score_acc (the value before any same-cycle event); score shall hold at all other times.
REQ-025 Hit or miss coincident with frame_tick: the event shall update score_acc, and the score output shall reflect it at the next frame_tick.
REQ-026 Start event coincident with frame_tick: score shall take the old score_acc; the cleared value shall appear at the following frame_tick.
REQ-027 Latency: hit_in high in cycle N -> score_acc updated at the edge ending cycle N -> score visible after the first frame_tick at or after cycle N+1.
REQ-028 A level held high shall count exactly once; a further event requires the input to return to 0 for at least one cycle.

Reset
REQ-029 While reset_n=0, asynchronously: state=IDLE, score=0, score_acc=0, lives=0, combo=0, playing=0, game_over=0, and all edge-detect registers=0.
REQ-030 Reset released mid-game shall return to IDLE with no pending score; an input held high across reset release shall produce an event on the first clock edge.

Verification
REQ-031 Reset, start pulse, 3 single-cycle hits, then frame_tick -> score=3, combo=3, lives=3, playing=1.
REQ-032 From PLAY with combo=0, 5 hits then frame_tick -> score=6 (1+1+1+1+2), combo=0.
REQ-033 score_acc=98, hit completing a combo, then frame_tick -> score=99; another hit, then frame_tick -> score=99.
REQ-034 From PLAY with lives=3, 3 misses -> lives=0, game_over=1, playing=0; further hits leave score unchanged; a start pulse -> PLAY, lives=3, and score=0 after the next frame_tick.
REQ-035 hit_in and miss_in rising together with combo=2 and lives=2 -> lives=1, combo=0, score_acc unchanged.
REQ-036 hit_in held high for 100 cycles spanning 2 frame_ticks -> exactly +1 to score; a hit coincident with frame_tick appears only at the next frame_tick.
